// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: grant state encoding and default widths.
`default_nettype none

package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam int DM_AW = 10;
  localparam int DM_DW = 32;

endpackage : dm_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
// Two-way round-robin grant state machine with a burst cap that only bites under contention.
`default_nettype none

module rr_arb2
  import dm_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req0,
  input  logic   req1,
  output state_t state
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BCAP = BW'(MAX_BURST - 1);

  state_t        state_nxt;
  logic          last;
  logic          last_nxt;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    bcnt_nxt  = bcnt;

    if (req0 && req1) begin
      case (state)
        G0:      state_nxt = (bcnt < BCAP) ? G0 : G1;
        G1:      state_nxt = (bcnt < BCAP) ? G1 : G0;
        default: state_nxt = last ? G0 : G1;
      endcase
    end else if (req0) begin
      state_nxt = G0;
    end else if (req1) begin
      state_nxt = G1;
    end

    // last records the owner on every fresh entry so an IDLE tie goes to the other master
    if (state_nxt != IDLE) begin
      if (state_nxt == state) begin
        if (bcnt < BCAP) bcnt_nxt = bcnt + 1'b1;
      end else begin
        bcnt_nxt = '0;
        last_nxt = (state_nxt == G1);
      end
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the CPU port (M0) and the DMA/debug loader (M1).
`default_nettype none

module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW        = DM_AW,
  parameter int DW        = DM_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  state_t state;

  rr_arb2 #(
    .MAX_BURST(MAX_BURST)
  ) u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_req),
    .req1 (m1_req),
    .state(state)
  );

  // Outputs decode straight from the state register so an async reset drops mem_we at once
  assign m0_ack = (state == G0);
  assign m1_ack = (state == G1);

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    case (state)
      G0: begin
        mem_addr = m0_addr;
        mem_din  = m0_wdata;
        mem_we   = m0_we;
      end
      G1: begin
        mem_addr = m1_addr;
        mem_din  = m1_wdata;
        mem_we   = m1_we;
      end
      default: ;
    endcase
  end

  assign m0_rdata = mem_dout;
  assign m1_rdata = mem_dout;

endmodule : dm_arbiter

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a grant/memory model.
`default_nettype none

module tb_dm_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int compared   = 0;
  int mismatched = 0;

  // Reference: owner (-1 none), length of the current run of grants, last owner
  int owner;
  int run;
  int last;
  bit            pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  bit            got0, got1;
  int            acks;

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    run    = 0;
    last   = 1;
    pend_v = 1'b0;
  endtask

  // One clock: decide the grant from the rules, check the DUT, then let the falling edge commit.
  task automatic step(input bit high_only = 1'b0);
    int nxt;
    @(posedge clk);
    #1;
    if (!m0_req && !m1_req)     nxt = -1;
    else if (m0_req != m1_req)  nxt = m0_req ? 0 : 1;
    else if (owner < 0)         nxt = (last == 1) ? 0 : 1;
    else if (run < MB)          nxt = owner;
    else                        nxt = 1 - owner;
    if (nxt >= 0) begin
      if (nxt == owner) run++;
      else begin
        run  = 1;
        last = nxt;
      end
    end
    owner = nxt;

    chk("m0_ack", {31'd0, m0_ack}, {31'd0, owner == 0});
    chk("m1_ack", {31'd0, m1_ack}, {31'd0, owner == 1});
    got0 = (owner == 0);
    got1 = (owner == 1);
    if (owner == 0) begin
      chk("mem_addr", {22'd0, mem_addr}, {22'd0, m0_addr});
      chk("mem_we",   {31'd0, mem_we},   {31'd0, m0_we});
      if (m0_we) chk("mem_din", mem_din, m0_wdata);
      else       chk("m0_rdata", m0_rdata, ref_mem[m0_addr]);
      if (m0_we) begin pend_v = 1'b1; pend_a = m0_addr; pend_d = m0_wdata; end
    end else if (owner == 1) begin
      chk("mem_addr", {22'd0, mem_addr}, {22'd0, m1_addr});
      chk("mem_we",   {31'd0, mem_we},   {31'd0, m1_we});
      if (m1_we) chk("mem_din", mem_din, m1_wdata);
      else       chk("m1_rdata", m1_rdata, ref_mem[m1_addr]);
      if (m1_we) begin pend_v = 1'b1; pend_a = m1_addr; pend_d = m1_wdata; end
    end else begin
      chk("idle_we",   {31'd0, mem_we}, 32'd0);
      chk("idle_addr", {22'd0, mem_addr}, 32'd0);
      chk("idle_din",  mem_din, 32'd0);
    end
    if (!high_only) begin
      @(negedge clk);
      #1;
      if (pend_v) ref_mem[pend_a] = pend_d;
      pend_v = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    got0 = 1'b0; got1 = 1'b0;

    // Reset with both masters requesting
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h001; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h002; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst_we",     {31'd0, mem_we}, 32'd0);
    chk("rst_addr",   {22'd0, mem_addr}, 32'd0);
    chk("rst_din",    mem_din, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention: first grant goes to M0, then runs of MB
    step();
    chk("first_grant_m0", {31'd0, m0_ack}, 32'd1);
    acks = m0_ack ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i < 3) acks += m0_ack ? 1 : 0;
    end
    chk("burst_m0_count", acks, MB);

    m0_req = 1'b0; m1_req = 1'b0;
    step();

    // Lone M0 write then read back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
    step();
    m0_we = 1'b0;
    step();
    chk("m0_readback", m0_rdata, 32'hDEADBEEF);
    m0_req = 1'b0;
    step();

    // Lone M1 for ten cycles: no burst cap
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h005;
    acks = 0;
    repeat (10) begin
      step();
      acks += m1_ack ? 1 : 0;
    end
    chk("m1_alone_acks", acks, 10);
    m1_req = 1'b0;
    step();

    // M0 writes the top word, M1 reads it on the very next cycle
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h3FF; m0_wdata = 32'h12345678;
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h3FF;
    step();
    chk("raw_3ff", m1_rdata, 32'h12345678);
    m1_req = 1'b0;
    step();

    // Random traffic; a pending request is held until acked
    for (int i = 0; i < 400; i++) begin
      if (!m0_req || got0) begin
        m0_req   = ($urandom_range(0, 9) < 7);
        m0_we    = $urandom_range(0, 1) == 1;
        m0_addr  = AW'($urandom_range(0, 15));
        m0_wdata = $urandom;
      end
      if (!m1_req || got1) begin
        m1_req   = ($urandom_range(0, 9) < 7);
        m1_we    = $urandom_range(0, 1) == 1;
        m1_addr  = AW'($urandom_range(0, 15));
        m1_wdata = $urandom;
      end
      step();
    end

    // Async reset in the high phase of an M1 write cycle
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h010; m1_wdata = ~ref_mem[10'h010];
    step(1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_we",     {31'd0, mem_we}, 32'd0);
    chk("arst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("arst_addr",   {22'd0, mem_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    chk("arst_no_write", mem[10'h010], ref_mem[10'h010]);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h010;
    m1_we  = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_idle", {30'd0, m1_ack, m0_ack}, 32'd0);
    step();
    chk("post_rst_m0", {31'd0, m0_ack}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_dm_arbiter

`default_nettype wire
